// File: rtl/pe_pkg.sv
// Shared constants and FSM state type for the PE operand feeder.
package pe_pkg;
  localparam int BIT_W       = 8;
  localparam int CH          = 2;
  localparam int WIN_ELEMS   = 9;
  localparam int KER_ELEMS   = CH * WIN_ELEMS;
  localparam int PE_IMAGE_W  = KER_ELEMS * BIT_W;
  localparam int PE_KERNEL_W = PE_IMAGE_W;

  typedef enum logic [1:0] {
    S_KER,
    S_STREAM,
    S_DRAIN
  } state_t;
endpackage

// File: rtl/pe_line_buf.sv
// Two-row line buffer for one channel; returns the column {row r-2, row r-1, row r} at col.
module pe_line_buf
  import pe_pkg::*;
#(
  parameter int IMG_W = 8
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(IMG_W)-1:0] col,
  input  logic [BIT_W-1:0]         pix,
  output logic [3*BIT_W-1:0]       column
);

  logic [BIT_W-1:0] row_old [IMG_W];
  logic [BIT_W-1:0] row_mid [IMG_W];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      row_old[col] <= row_mid[col];
      row_mid[col] <= pix;
    end
  end

  assign column = {row_old[col], row_mid[col], pix};

endmodule

// File: rtl/pe_window_feeder.sv
// Kernel loader, 3x3x2 window builder and output register feeding the PE operand buses.
module pe_window_feeder
  import pe_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_ker_valid,
  input  logic [BIT_W-1:0]       i_ker_data,
  output logic                   o_ker_ready,
  input  logic                   i_pix_valid,
  input  logic [CH*BIT_W-1:0]    i_pix_data,
  output logic                   o_pix_ready,
  output logic                   o_win_valid,
  input  logic                   i_win_ready,
  output logic [PE_IMAGE_W-1:0]  o_pe_image,
  output logic [PE_KERNEL_W-1:0] o_pe_kernel,
  output logic                   o_win_last,
  output logic                   o_frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int KW = $clog2(KER_ELEMS);

  state_t                           state;
  logic [CW-1:0]                    col;
  logic [RW-1:0]                    row;
  logic [KW-1:0]                    ker_cnt;
  logic [PE_KERNEL_W-1:0]           ker;
  // Ascending packed ranges put ch0 r0c0 in the most significant byte.
  logic [0:CH-1][0:2][0:2][BIT_W-1:0] win, win_next;
  logic [CH-1:0][3*BIT_W-1:0]       column;
  logic pix_fire, ker_fire, win_fire, last_col, last_row, emit;

  assign o_ker_ready = (state == S_KER);
  assign o_pix_ready = (state == S_STREAM) && (!o_win_valid || i_win_ready);
  assign o_pe_kernel = ker;

  assign ker_fire = i_ker_valid && o_ker_ready;
  assign pix_fire = i_pix_valid && o_pix_ready;
  assign win_fire = o_win_valid && i_win_ready;
  assign last_col = (col == CW'(IMG_W - 1));
  assign last_row = (row == RW'(IMG_H - 1));
  assign emit     = pix_fire && (row >= RW'(2)) && (col >= CW'(2));

  for (genvar g = 0; g < CH; g++) begin : g_ch
    pe_line_buf #(.IMG_W(IMG_W)) u_line_buf (
      .clk    (i_clk),
      .wr_en  (pix_fire),
      .col    (col),
      .pix    (i_pix_data[(CH-1-g)*BIT_W +: BIT_W]),
      .column (column[g])
    );
    for (genvar r = 0; r < 3; r++) begin : g_row
      assign win_next[g][r] = {win[g][r][1], win[g][r][2], column[g][(2-r)*BIT_W +: BIT_W]};
    end
  end

  always_ff @(posedge i_clk) begin
    if (pix_fire) win <= win_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= S_KER;
      row          <= '0;
      col          <= '0;
      ker_cnt      <= '0;
      ker          <= '0;
      o_win_valid  <= 1'b0;
      o_win_last   <= 1'b0;
      o_frame_done <= 1'b0;
      o_pe_image   <= '0;
    end else begin
      o_frame_done <= 1'b0;
      unique case (state)
        S_KER: begin
          if (ker_fire) begin
            ker <= {ker[PE_KERNEL_W-BIT_W-1:0], i_ker_data};
            if (ker_cnt == KW'(KER_ELEMS - 1)) begin
              ker_cnt <= '0;
              state   <= S_STREAM;
            end else begin
              ker_cnt <= ker_cnt + 1'b1;
            end
          end
        end
        S_STREAM: begin
          if (pix_fire) begin
            if (last_col) begin
              col <= '0;
              row <= last_row ? '0 : row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
            if (last_col && last_row) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (win_fire && o_win_last) begin
            state        <= S_KER;
            o_frame_done <= 1'b1;
          end
        end
        default: state <= S_KER;
      endcase
      // A new window wins over the handshake so back-to-back windows keep full throughput.
      if (emit) begin
        o_pe_image  <= win_next;
        o_win_valid <= 1'b1;
        o_win_last  <= last_col && last_row;
      end else if (win_fire) begin
        o_win_valid <= 1'b0;
        o_win_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pe_window_feeder.sv
// Randomized self-checking bench for pe_window_feeder against a frame-level window model.
module tb_pe_window_feeder;
  localparam int IMG_W = 4;
  localparam int IMG_H = 4;
  localparam int NWIN  = (IMG_H - 2) * (IMG_W - 2);

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_ker_valid;
  logic [7:0]   i_ker_data;
  logic         o_ker_ready;
  logic         i_pix_valid;
  logic [15:0]  i_pix_data;
  logic         o_pix_ready;
  logic         o_win_valid;
  logic         i_win_ready;
  logic [143:0] o_pe_image;
  logic [143:0] o_pe_kernel;
  logic         o_win_last;
  logic         o_frame_done;

  pe_window_feeder #(.IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_ker_valid  (i_ker_valid),
    .i_ker_data   (i_ker_data),
    .o_ker_ready  (o_ker_ready),
    .i_pix_valid  (i_pix_valid),
    .i_pix_data   (i_pix_data),
    .o_pix_ready  (o_pix_ready),
    .o_win_valid  (o_win_valid),
    .i_win_ready  (i_win_ready),
    .o_pe_image   (o_pe_image),
    .o_pe_kernel  (o_pe_kernel),
    .o_win_last   (o_win_last),
    .o_frame_done (o_frame_done)
  );

  always #5 i_clk = ~i_clk;

  int           checks = 0;
  int           errors = 0;
  logic [15:0]  pix [IMG_H][IMG_W];
  logic [7:0]   ker_bytes [18];
  logic [143:0] exp_q [$];
  logic [143:0] exp_ker = '0;
  int           win_cnt = 0;
  bit           mon_en = 1'b0;
  bit           last_hs = 1'b0;

  task automatic check(input string tag, input logic [143:0] got, input logic [143:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Window at bottom-right (r,c): rows r-2..r, cols c-2..c, ch0 block then ch1 block.
  function automatic logic [143:0] win_of(int r, int c);
    logic [143:0] w;
    logic [15:0]  p;
    int           e;
    w = '0;
    e = 0;
    for (int ch = 0; ch < 2; ch++)
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) begin
          p = pix[r-2+i][c-2+j];
          w[143-8*e -: 8] = (ch == 0) ? p[15:8] : p[7:0];
          e++;
        end
    return w;
  endfunction

  task automatic prep_frame(input bit rnd);
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        pix[r][c] = rnd ? 16'($urandom) : {8'(IMG_W*r + c), 8'(8'h10 + IMG_W*r + c)};
    exp_q.delete();
    for (int r = 2; r < IMG_H; r++)
      for (int c = 2; c < IMG_W; c++)
        exp_q.push_back(win_of(r, c));
    win_cnt = 0;
  endtask

  task automatic load_kernel(input bit rnd);
    bit fire;
    int guard;
    for (int k = 0; k < 18; k++) ker_bytes[k] = rnd ? 8'($urandom) : 8'(k + 1);
    exp_ker = '0;
    for (int k = 0; k < 18; k++) exp_ker[143-8*k -: 8] = ker_bytes[k];
    for (int k = 0; k < 18; k++) begin
      i_ker_valid = 1'b1;
      i_ker_data  = ker_bytes[k];
      fire  = 1'b0;
      guard = 0;
      while (!fire && guard < 20) begin
        @(negedge i_clk);
        fire = o_ker_ready;
        guard++;
        @(posedge i_clk); #1;
      end
      check("ker_accept", 144'(fire), 144'(1));
    end
    i_ker_valid = 1'b0;
    @(negedge i_clk);
    check("ker_ready_low", 144'(o_ker_ready), 144'(0));
    check("ker_value", o_pe_kernel, exp_ker);
    @(posedge i_clk); #1;
    i_ker_valid = 1'b1;
    i_ker_data  = 8'hEE;
    repeat (2) @(posedge i_clk);
    #1;
    i_ker_valid = 1'b0;
    @(negedge i_clk);
    check("ker_extra_ignored", o_pe_kernel, exp_ker);
    @(posedge i_clk); #1;
  endtask

  task automatic feed_frame(input int gap_pct, input int rdy_pct, input bit stall_first,
                            input bit directed, input int max_pix);
    int r, c, acc, guard, stall_left, k;
    bit fire, pend, stalled, done;
    r = 0; c = 0; acc = 0; guard = 0; stall_left = 0;
    pend = 1'b0; stalled = 1'b0;
    while (acc < max_pix && guard < 2000) begin
      guard++;
      if (stall_first && !stalled && o_win_valid) begin
        stall_left = 5;
        stalled    = 1'b1;
      end
      i_pix_valid = ($urandom_range(99) >= gap_pct);
      i_pix_data  = pix[r][c];
      i_win_ready = (stall_left > 0) ? 1'b0 : ($urandom_range(99) < rdy_pct);
      @(negedge i_clk);
      if (pend) check("latency", 144'(o_win_valid), 144'(1));
      if (directed && !stall_first) check("win_valid", 144'(o_win_valid), 144'(pend));
      if (stall_left > 0) begin
        check("stall_pix_ready", 144'(o_pix_ready), 144'(0));
        check("stall_image", o_pe_image, win_of(2, 2));
        stall_left--;
      end
      fire = i_pix_valid && o_pix_ready;
      pend = fire && (r >= 2) && (c >= 2);
      @(posedge i_clk); #1;
      if (fire) begin
        acc++;
        if (c == IMG_W - 1) begin
          c = 0;
          r++;
        end else begin
          c++;
        end
      end
    end
    check("feed_done", 144'(acc), 144'(max_pix));
    i_pix_valid = 1'b0;
    if (max_pix == IMG_W * IMG_H) begin
      done = 1'b0;
      k = 0;
      while (!done && k < 100) begin
        k++;
        i_win_ready = ($urandom_range(99) < rdy_pct);
        @(negedge i_clk);
        if (pend) begin
          check("latency", 144'(o_win_valid), 144'(1));
          pend = 1'b0;
        end
        if (o_frame_done) begin
          done = 1'b1;
          check("ker_ready_again", 144'(o_ker_ready), 144'(1));
        end
        @(posedge i_clk); #1;
      end
      check("frame_done_seen", 144'(done), 144'(1));
      check("win_count", 144'(win_cnt), 144'(NWIN));
      check("exp_q_empty", 144'(exp_q.size()), 144'(0));
    end
  endtask

  // Consumes one expected window per output handshake; frame_done must follow the last one.
  always @(negedge i_clk) begin
    logic [143:0] e;
    if (mon_en) begin
      check("frame_done", 144'(o_frame_done), 144'(last_hs));
      last_hs = 1'b0;
      if (o_win_valid && i_win_ready) begin
        win_cnt++;
        check("win_expected", 144'(exp_q.size() != 0), 144'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("win_image", o_pe_image, e);
          check("win_kernel", o_pe_kernel, exp_ker);
          check("win_last", 144'(o_win_last), 144'(exp_q.size() == 0));
          last_hs = (exp_q.size() == 0);
        end
      end
    end
  end

  initial begin
    i_rst = 1'b1;
    i_ker_valid = 1'b0;
    i_ker_data = '0;
    i_pix_valid = 1'b0;
    i_pix_data = '0;
    i_win_ready = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    check("rst_win_valid", 144'(o_win_valid), 144'(0));
    check("rst_ker_ready", 144'(o_ker_ready), 144'(1));
    check("rst_pix_ready", 144'(o_pix_ready), 144'(0));
    check("rst_image", o_pe_image, 144'(0));
    check("rst_kernel", o_pe_kernel, 144'(0));
    check("rst_win_last", 144'(o_win_last), 144'(0));
    check("rst_frame_done", 144'(o_frame_done), 144'(0));
    @(posedge i_clk); #1;
    mon_en = 1'b1;

    load_kernel(1'b0);
    prep_frame(1'b0);
    feed_frame(0, 100, 1'b0, 1'b1, IMG_W * IMG_H);

    load_kernel(1'b0);
    prep_frame(1'b0);
    feed_frame(0, 100, 1'b1, 1'b0, IMG_W * IMG_H);

    for (int f = 0; f < 3; f++) begin
      load_kernel(1'b1);
      prep_frame(1'b1);
      feed_frame(50, 50, 1'b0, 1'b0, IMG_W * IMG_H);
    end

    load_kernel(1'b0);
    prep_frame(1'b0);
    feed_frame(0, 100, 1'b0, 1'b1, 2 * IMG_W + 4);
    i_win_ready = 1'b0;
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    exp_q.delete();
    @(negedge i_clk);
    check("midrst_win_valid", 144'(o_win_valid), 144'(0));
    check("midrst_ker_ready", 144'(o_ker_ready), 144'(1));
    check("midrst_pix_ready", 144'(o_pix_ready), 144'(0));
    check("midrst_kernel", o_pe_kernel, 144'(0));
    @(posedge i_clk); #1;
    load_kernel(1'b0);
    prep_frame(1'b0);
    feed_frame(0, 100, 1'b0, 1'b1, IMG_W * IMG_H);

    repeat (2) @(posedge i_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
